// File: rtl/instr_mem_loadable_if.sv
// Loader / fetch bus of the loadable instruction memory.
//   master : the side that loads programs and issues fetches (testbench, fetch stage)
//   slave  : the instruction memory
// Load channel : load_start, load_valid, load_last, load_data -> load_ready, load_count
// Fetch channel: fetch_req, fetch_addr, fetch_stall -> instr_out, instr_valid, addr_fault
// Status       : busy (memory is not in RUN)
interface instr_mem_loadable_if #(
  parameter int INSTR_W = 9,
  parameter int ADDR_W  = 9
);
  logic               load_start;
  logic               load_valid;
  logic               load_last;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic [ADDR_W-1:0]  load_count;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_stall;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               addr_fault;
  logic               busy;

  modport master (
    output load_start, load_valid, load_last, load_data,
    output fetch_req, fetch_addr, fetch_stall,
    input  load_ready, load_count,
    input  instr_out, instr_valid, addr_fault, busy
  );

  modport slave (
    input  load_start, load_valid, load_last, load_data,
    input  fetch_req, fetch_addr, fetch_stall,
    output load_ready, load_count,
    output instr_out, instr_valid, addr_fault, busy
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory for the 9-bit-ISA core.
// A program is streamed in word by word (EMPTY/LOAD), after which the fetch
// stage reads it with one-cycle latency and a registered response (RUN).
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-high
//   bus   : instr_mem_loadable_if.slave (load channel, fetch channel, busy)
module instr_mem_loadable #(
  parameter int                 ROM_SIZE = 256,
  parameter int                 INSTR_W  = 9,
  parameter int                 ADDR_W   = $clog2(ROM_SIZE) + 1,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loadable_if.slave  bus
);

  localparam int                IDX_W      = $clog2(ROM_SIZE);
  localparam logic [ADDR_W-1:0] ROM_SIZE_A = ADDR_W'(ROM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(ROM_SIZE - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    load_count_q, load_count_d;
  logic                 load_ready_q, load_ready_d;
  logic                 busy_q, busy_d;
  logic [INSTR_W-1:0]   instr_out_q, instr_out_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 addr_fault_q, addr_fault_d;

  logic [INSTR_W-1:0]   rom [ROM_SIZE];
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [INSTR_W-1:0]   rd_word;

  // Word counter never exceeds the array size.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (v >= ROM_SIZE_A) ? ROM_SIZE_A : v + ADDR_W'(1);
  endfunction

  // load_count doubles as the write pointer; it is always < ROM_SIZE while
  // in LOAD, so its low bits index the array directly.
  assign wr_idx  = load_count_q[IDX_W-1:0];
  assign rd_idx  = bus.fetch_addr[IDX_W-1:0];
  assign rd_word = rom[rd_idx];
  // load_start wins over a word offered in the same cycle.
  assign wr_en   = (state_q == S_LOAD) && bus.load_valid && !bus.load_start;

  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = instr_valid_q;
    addr_fault_d  = addr_fault_q;

    case (state_q)
      S_EMPTY: begin
        instr_valid_d = 1'b0;
        addr_fault_d  = 1'b0;
        if (bus.load_start) begin
          state_d      = S_LOAD;
          load_count_d = '0;
        end
      end

      S_LOAD: begin
        instr_valid_d = 1'b0;
        addr_fault_d  = 1'b0;
        if (bus.load_start) begin
          // Restart from word 0; the array keeps its old contents.
          load_count_d = '0;
        end else if (bus.load_valid) begin
          load_count_d = sat_inc(load_count_q);
          if (bus.load_last || (load_count_q == LAST_IDX)) begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (bus.load_start) begin
          // Reload request drops any fetch offered in the same cycle.
          state_d       = S_LOAD;
          load_count_d  = '0;
          instr_valid_d = 1'b0;
          addr_fault_d  = 1'b0;
        end else if (!bus.fetch_stall) begin
          if (bus.fetch_req) begin
            instr_valid_d = 1'b1;
            // Unsigned compare at full ADDR_W also rejects addresses >= ROM_SIZE.
            if (bus.fetch_addr >= load_count_q) begin
              instr_out_d  = NOP_WORD;
              addr_fault_d = 1'b1;
            end else begin
              instr_out_d  = rd_word;
              addr_fault_d = 1'b0;
            end
          end else begin
            instr_valid_d = 1'b0;
            addr_fault_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_EMPTY;
      end
    endcase

    load_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      load_count_q  <= '0;
      load_ready_q  <= 1'b0;
      busy_q        <= 1'b1;
      instr_out_q   <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      load_ready_q  <= load_ready_d;
      busy_q        <= busy_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      addr_fault_q  <= addr_fault_d;
    end
  end

  // Program storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rom[wr_idx] <= bus.load_data;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.load_count  = load_count_q;
  assign bus.busy        = busy_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.addr_fault  = addr_fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: fetch tasks push the hand-computed
// response {addr_fault, instr_out}; a negedge monitor pops and compares each
// new response and checks held responses during stalls.
module tb_instr_mem_loadable;
  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_loadable #(
    .ROM_SIZE(256), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NOP_WORD(9'h000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q [$];
  logic [9:0] last_exp = '0;
  logic       stall_s  = 1'b0;

  logic [8:0] prog1 [19] = '{9'h0C0, 9'h143, 9'h046, 9'h1A5, 9'h07E, 9'h112, 9'h003,
                             9'h1FF, 9'h080, 9'h0AA, 9'h155, 9'h0F0, 9'h10F, 9'h033,
                             9'h1CC, 9'h066, 9'h199, 9'h024, 9'h1E7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: stall seen at the producing edge means the response is held.
  always @(posedge clk) stall_s <= bus.fetch_stall;

  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1) begin
      if (stall_s) begin
        check("held_resp", {bus.addr_fault, bus.instr_out}, last_exp);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got 0x%0h with no response expected",
                 {bus.addr_fault, bus.instr_out});
      end else begin
        last_exp = exp_q.pop_front();
        check("fetch_resp", {bus.addr_fault, bus.instr_out}, last_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [8:0] addr, input logic [8:0] d, input logic f);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    exp_q.push_back({f, d});
    step();
    bus.fetch_req  = 1'b0;
  endtask

  task automatic start_load(input logic with_fetch);
    bus.load_start = 1'b1;
    bus.fetch_req  = with_fetch;
    bus.fetch_addr = '0;
    step();
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
  endtask

  task automatic load_word(input logic [8:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    step();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  initial begin
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_last   = 1'b0;
    bus.load_data   = '0;
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.fetch_stall = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("rst_instr_out",   bus.instr_out,   9'h000);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_addr_fault",  bus.addr_fault,  1'b0);
    check("rst_busy",        bus.busy,        1'b1);
    check("rst_load_ready",  bus.load_ready,  1'b0);
    check("rst_load_count",  bus.load_count,  9'd0);
    reset = 1'b0;
    step();

    // Scenario 1: 19-word program terminated by load_last
    start_load(1'b0);
    check("s1_load_ready", bus.load_ready, 1'b1);
    for (int i = 0; i < 19; i++) load_word(prog1[i], (i == 18));
    check("s1_load_count", bus.load_count, 9'd19);
    check("s1_busy",       bus.busy,       1'b0);
    check("s1_ready_low",  bus.load_ready, 1'b0);
    fetch(9'd0, 9'h0C0, 1'b0);
    fetch(9'd1, 9'h143, 1'b0);
    step();
    check("s1_idle_valid", bus.instr_valid, 1'b0);
    check("s1_idle_hold",  bus.instr_out,   9'h143);

    // Scenario 2: unloaded / out-of-range / last loaded word
    fetch(9'd19,   9'h000, 1'b1);
    fetch(9'h100,  9'h000, 1'b1);
    fetch(9'd18,   9'h1E7, 1'b0);

    // Scenario 3: stall holds the response, pending request ignored
    fetch(9'd2, 9'h046, 1'b0);
    bus.fetch_stall = 1'b1;
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = 9'd5;
    repeat (3) step();
    check("s3_stall_out", bus.instr_out, 9'h046);
    bus.fetch_stall = 1'b0;
    fetch(9'd5, 9'h112, 1'b0);
    step();

    // Scenario 4: full 256-word load without load_last
    start_load(1'b0);
    for (int i = 0; i < 256; i++) load_word(9'(i), 1'b0);
    check("s4_load_count", bus.load_count, 9'h100);
    check("s4_busy",       bus.busy,       1'b0);
    fetch(9'd255, 9'h0FF, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = 9'h1FF;
    step();
    bus.load_valid = 1'b0;
    fetch(9'd0, 9'h000, 1'b0);

    // Scenario 5: reload during RUN, colliding fetch dropped
    start_load(1'b1);
    check("s5_valid_drop", bus.instr_valid, 1'b0);
    check("s5_busy",       bus.busy,        1'b1);
    load_word(9'h1AA, 1'b0);
    load_word(9'h055, 1'b1);
    check("s5_load_count", bus.load_count, 9'd2);
    fetch(9'd1, 9'h055, 1'b0);
    fetch(9'd2, 9'h000, 1'b1);
    fetch(9'd1, 9'h055, 1'b0);
    step();

    // Scenario 6: asynchronous reset in the middle of a load
    start_load(1'b0);
    for (int i = 0; i < 5; i++) load_word(9'(i + 16), 1'b0);
    check("s6_count_mid", bus.load_count, 9'd5);
    #3;
    reset = 1'b1;
    #1;
    check("s6_rst_out",   bus.instr_out,  9'h000);
    check("s6_rst_busy",  bus.busy,       1'b1);
    check("s6_rst_ready", bus.load_ready, 1'b0);
    check("s6_rst_count", bus.load_count, 9'd0);
    step();
    reset = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 9'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s6_empty_valid", bus.instr_valid, 1'b0);
    end
    bus.fetch_req = 1'b0;
    start_load(1'b0);
    load_word(9'h0AB, 1'b1);
    fetch(9'd0, 9'h0AB, 1'b0);
    step();
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Next-generation instruction memory for the 9-bit-ISA core.
- Replaces the hard-wired ROM with a runtime-loadable array, written word by word from the testbench/loader port.
- Read is synchronous: one-cycle latency, registered output, stall support, address-fault flag.
- Sits between the program counter/fetch stage and the testbench loader.

Parameters:
- ROM_SIZE, 256, number of instruction words.
- INSTR_W, 9, instruction width in bits.
- ADDR_W, $clog2(ROM_SIZE)+1, fetch address width; the extra bit allows out-of-range detection.
- NOP_WORD, 0, word returned on faulted or unloaded fetches.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  pulse: begin a new program load at address 0.
- load_valid  input  1  load_data holds a valid word this cycle.
- load_last  input  1  qualifies load_valid: this is the final word.
- load_data  input  INSTR_W  instruction word to store.
- load_ready  output  1  high in LOAD state; a word is accepted when load_valid and load_ready are both high.
- load_count  output  ADDR_W  number of words loaded so far.
- fetch_req  input  1  fetch request.
- fetch_addr  input  ADDR_W  word address to fetch.
- fetch_stall  input  1  hold the current response; ignore fetch_req.
- instr_out  output  INSTR_W  registered fetched instruction.
- instr_valid  output  1  instr_out holds a response.
- addr_fault  output  1  current response is out of range or unloaded.
- busy  output  1  high when state is not RUN.

Behaviour:
- Reset is asynchronous. Reset values:
  - state=EMPTY, load_count=0, load_ready=0.
  - instr_out=NOP_WORD, instr_valid=0, addr_fault=0, busy=1.
  - The array itself is not reset.
- State EMPTY:
  - Fetches are ignored; instr_valid=0.
  - load_start goes to LOAD.
- State LOAD:
  - On entry, the write pointer is 0 and load_count is 0.
  - Each accepted word: rom[ptr] <= load_data; ptr and load_count increment.
  - Go to RUN after the word with load_last=1, or after the word written at ROM_SIZE-1 (the pointer never wraps).
  - load_valid outside LOAD is ignored.
  - load_start in LOAD restarts at 0 and discards load_count, but does not erase the array.
  - Fetches are ignored; instr_valid is forced to 0.
- State RUN:
  - load_start goes to LOAD. instr_valid drops to 0 the cycle after load_start is seen.
  - Otherwise the state stays in RUN.
- Fetch timing (RUN only):
  - A request with fetch_req=1 and fetch_stall=0 in cycle N produces the response in cycle N+1.
  - instr_out = rom[fetch_addr], instr_valid=1, addr_fault=0.
  - If fetch_addr >= load_count (which also covers >= ROM_SIZE): instr_out=NOP_WORD, addr_fault=1, instr_valid=1.
  - fetch_req=0 without stall: instr_valid=0 next cycle; instr_out holds its last value.
  - fetch_stall=1: instr_out, instr_valid and addr_fault all hold, and fetch_req is ignored.
  - Back-to-back requests give one response per cycle.
- Simultaneous events:
  - load_start has priority over fetch_req in the same cycle; the fetch is dropped.
  - A load of the final word and a fetch in the same cycle: the fetch is ignored, because state is still LOAD.
- Reset mid-load: state returns to EMPTY, and the partially written array contents are don't-care.
- Write and read never occur in the same cycle.
- Widths: load_count saturates at ROM_SIZE. Address compares are unsigned at ADDR_W.

Test Plan:
1. Reset, load 19 words (0x0C0, 0x143, 0x046, ...) with load_last on word 19.
   - Required: load_count=19, busy=0.
   - Fetch addr 0 -> next cycle instr_out=0x0C0, instr_valid=1; addr 1 -> 0x143.
2. Unloaded and out-of-range fetches, after scenario 1:
   - Fetch addr 19 -> instr_out=0x000, addr_fault=1.
   - Fetch addr 256 (ADDR_W=9) -> NOP_WORD, addr_fault=1.
   - Fetch addr 18 -> valid data, addr_fault=0.
3. Stall:
   - Fetch addr 2 (0x046), then fetch_stall=1 for 3 cycles while fetch_addr=5 and fetch_req=1 -> instr_out stays 0x046 with instr_valid=1.
   - Release the stall -> response for addr 5 on the next cycle.
4. Full load of 256 words without load_last:
   - Word i = i[8:0]; auto-transition to RUN after word 255, load_count=256.
   - Fetch addr 255 -> 0x0FF.
   - A further load_valid in RUN is ignored (rom[0] stays 0x000).
5. Reload during RUN:
   - load_start in the same cycle as fetch_req -> fetch dropped, instr_valid=0, busy=1.
   - Load 2 words (0x1AA, 0x055) -> fetch addr 1 = 0x055; addr 2 -> addr_fault=1.
6. Reset asserted asynchronously mid-load (after 5 words, between clock edges):
   - Outputs go to reset values immediately; state=EMPTY.
   - A fetch after deassertion gives instr_valid=0 until a new load completes.
